// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - Parametrised SPI master, four modes, multiple slave selects, start/busy/done handshake
// Build option SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds mosi back into the receive path.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 1,
    parameter int SS_W    = 1,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [NUM_SS-1:0] ss_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W - 1);
    localparam logic [31:0]      NUM_SS_U = NUM_SS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [TOG_W-1:0]  r_tog;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;
    logic [NUM_SS-1:0] r_ss_n;

    logic              w_accept;
    logic              w_half_end;
    logic              w_lead_edge;
    logic              w_rx_bit;
    logic [NUM_SS-1:0] w_ss_onehot;

    // Out-of-range slave indices never start a transfer.
    assign w_accept    = start && (32'(ss_sel) < NUM_SS_U) &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_half_end  = (r_div == DIV_LAST);
    assign w_lead_edge = ~r_tog[0];
    assign w_ss_onehot = NUM_SS'(1) << ss_sel;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic r_loopback;
    assign w_rx_bit = r_loopback ? r_mosi : miso;
`else
    assign w_rx_bit = miso;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_tog     <= '0;
            r_mode    <= 2'b00;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ss_n    <= '1;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loopback <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ss_n  <= '1;
                    r_mosi  <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_LEAD;
                        r_busy  <= 1'b1;
                        r_mode  <= mode;
                        r_tx    <= tx_data;
                        r_rx    <= '0;
                        r_div   <= '0;
                        r_tog   <= '0;
                        r_sclk  <= mode[1];
                        r_mosi  <= mode[0] ? 1'b0 : tx_data[DATA_W-1];
                        r_ss_n  <= ~w_ss_onehot;
`ifdef SPI_MASTER_LOOPBACK_EN
                        r_loopback <= loopback;
`endif
                    end
                end
                S_LEAD: begin
                    if (w_half_end) begin
                        r_div   <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_half_end) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + TOG_W'(1);
                        if (w_lead_edge) begin
                            if (r_mode[0]) begin
                                r_mosi <= r_tx[DATA_W-1];
                                r_tx   <= r_tx << 1;
                            end else begin
                                r_rx <= {r_rx[DATA_W-2:0], w_rx_bit};
                            end
                        end else begin
                            if (r_mode[0]) begin
                                r_rx <= {r_rx[DATA_W-2:0], w_rx_bit};
                            end else if (r_tog != TOG_LAST) begin
                                // CPHA=0 preloads the MSB in LEAD, so r_tx[MSB-1] is the next bit out.
                                r_mosi <= r_tx[DATA_W-2];
                                r_tx   <= r_tx << 1;
                            end
                        end
                        if (r_tog == TOG_LAST) begin
                            r_state <= S_TRAIL;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_half_end) begin
                        r_div     <= '0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_ss_n    <= '1;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign ss_n    = r_ss_n;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - Scoreboard bench for spi_master_param (8-bit/4-slave and 16-bit/div-1 instances)
module tb_spi_master_param;

    localparam int DW  = 8;
    localparam int NSS = 4;
    localparam int SSW = 3;
    localparam int CDV = 4;
    localparam int DW2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst     = 1'b1;
    logic           start   = 1'b0;
    logic [1:0]     mode    = 2'd0;
    logic [SSW-1:0] ss_sel  = '0;
    logic [DW-1:0]  tx_data = '0;
    logic [DW-1:0]  rx_data;
    logic           busy, done, sclk, mosi, miso;
    logic [NSS-1:0] ss_n;
    logic           tie_loop = 1'b1;
    logic           s_miso   = 1'b0;
    assign miso = tie_loop ? mosi : s_miso;

    logic           start2 = 1'b0;
    logic [1:0]     mode2  = 2'd0;
    logic [0:0]     ss_sel2 = 1'b0;
    logic [DW2-1:0] tx2    = '0;
    logic [DW2-1:0] rx2;
    logic           busy2, done2, sclk2, mosi2;
    logic [0:0]     ss_n2;

    spi_master_param #(.DATA_W(DW), .NUM_SS(NSS), .SS_W(SSW), .CLK_DIV(CDV)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ss_sel(ss_sel),
        .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
        .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .ss_n(ss_n)
    );

    spi_master_param #(.DATA_W(DW2), .NUM_SS(1), .SS_W(1), .CLK_DIV(1)) u_dut16 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .ss_sel(ss_sel2),
        .tx_data(tx2), .rx_data(rx2), .busy(busy2), .done(done2),
        .sclk(sclk2), .mosi(mosi2), .miso(mosi2),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .ss_n(ss_n2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: expectations pushed at issue time, popped on every done pulse.
    logic [DW-1:0]  exp_q[$];
    logic [DW2-1:0] exp_q2[$];
    int done_cnt = 0, done_cyc = 0, done2_cnt = 0, done2_cyc = 0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
            else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (done2 === 1'b1) begin
            done2_cnt <= done2_cnt + 1;
            done2_cyc <= cyc;
            if (exp_q2.size() == 0) check("spurious_done16", 32'(done2), 32'd0);
            else check("rx_data16", 32'(rx2), 32'(exp_q2.pop_front()));
        end
    end

    logic           mon_en    = 1'b0;
    logic           prev_sclk = 1'b0;
    logic [NSS-1:0] exp_ssn   = '1;
    int busy_cnt = 0, tog_cnt = 0, ss_bad = 0, rule_bad = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            prev_sclk <= sclk;
            if (sclk !== prev_sclk) tog_cnt <= tog_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (busy && (ss_n !== exp_ssn)) ss_bad <= ss_bad + 1;
            if (busy ? ($countones(~ss_n) != 1) : (ss_n !== '1)) rule_bad <= rule_bad + 1;
            if (busy2 ? (ss_n2 !== 1'b0) : (ss_n2 !== 1'b1)) rule_bad <= rule_bad + 1;
        end
    end

    // Mode-aware slave: preloads on select, samples/shifts on the edges its mode calls for.
    logic [1:0] s_mode = 2'd0;
    logic [7:0] s_word = 8'h00;
    int         s_idx  = 0;
    logic [7:0] s_sh = 8'h00, s_rx = 8'h00;
    logic       s_prev_ss = 1'b1, s_prev_sclk = 1'b0;

    always @(negedge clk) begin
        s_prev_ss   <= ss_n[s_idx];
        s_prev_sclk <= sclk;
        if (s_prev_ss && !ss_n[s_idx]) begin
            s_rx   <= 8'h00;
            s_miso <= s_mode[0] ? 1'b0 : s_word[7];
            s_sh   <= s_mode[0] ? s_word : (s_word << 1);
        end else if (!ss_n[s_idx] && (sclk !== s_prev_sclk)) begin
            if ((sclk != s_mode[1]) != s_mode[0]) begin
                s_rx <= {s_rx[6:0], mosi};
            end else begin
                s_miso <= s_sh[7];
                s_sh   <= s_sh << 1;
            end
        end
    end

    task automatic go(input logic [1:0] m, input int sel, input logic [DW-1:0] d, input bit loop,
                      input logic [DW-1:0] exp_rx, input bit push, output int k);
        @(negedge clk);
        tie_loop = loop;
        mode     = m;
        ss_sel   = SSW'(sel);
        tx_data  = d;
        start    = 1'b1;
        if (sel < NSS) exp_ssn = ~(NSS'(1) << sel);
        if (push) exp_q.push_back(exp_rx);
        k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) return;
        end
        check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    logic [1:0]     tm   [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    int             ts   [4] = '{1, 3, 2, 0};
    logic [7:0]     ttx  [4] = '{8'hC3, 8'h7E, 8'h4B, 8'h69};
    logic [7:0]     tsl  [4] = '{8'h3C, 8'h81, 8'hD2, 8'h96};
    logic [NSS-1:0] tssn [4] = '{4'b1101, 4'b0111, 4'b1011, 4'b1110};

    initial begin
        int k, k2, b0, t0, d0, target;

        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_sclk",  32'(sclk),    32'd0);
        check("rst_mosi",  32'(mosi),    32'd0);
        check("rst_ss_n",  32'(ss_n),    32'hF);
        check("rst_rx",    32'(rx_data), 32'd0);
        check("rst_rx16",  32'(rx2),     32'd0);
        check("rst_ss_n16", 32'(ss_n2),  32'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // mosi looped to miso, mode 0, 0xA5
        b0 = busy_cnt;
        t0 = tog_cnt;
        go(2'd0, 0, 8'hA5, 1'b1, 8'hA5, 1'b1, k);
        wait_done(200);
        check("a5_latency",  32'(done_cyc - k),   32'd73);
        check("a5_busy_cyc", 32'(busy_cnt - b0),  32'd72);
        check("a5_toggles",  32'(tog_cnt - t0),   32'd16);

        for (int i = 0; i < 4; i++) begin
            s_mode = tm[i];
            s_word = tsl[i];
            s_idx  = ts[i];
            go(tm[i], ts[i], ttx[i], 1'b0, tsl[i], 1'b1, k);
            check($sformatf("m%0d_sclk_lead", tm[i]), 32'(sclk), 32'(tm[i][1]));
            check($sformatf("m%0d_ss_n_lead", tm[i]), 32'(ss_n), 32'(tssn[i]));
            wait_done(200);
            check($sformatf("m%0d_slave_rx", tm[i]), 32'(s_rx), 32'(ttx[i]));
            check($sformatf("m%0d_sclk_idle", tm[i]), 32'(sclk), 32'(tm[i][1]));
            check($sformatf("m%0d_latency", tm[i]), 32'(done_cyc - k), 32'd73);
        end

        // ss_sel beyond NUM_SS
        d0 = done_cnt;
        b0 = busy_cnt;
        go(2'd0, 5, 8'hFF, 1'b1, 8'h00, 1'b0, k);
        repeat (100) @(negedge clk);
        check("badsel_busy", 32'(busy_cnt - b0), 32'd0);
        check("badsel_done", 32'(done_cnt - d0), 32'd0);

        // reset during XFER
        go(2'd0, 0, 8'h96, 1'b1, 8'h00, 1'b0, k);
        while (cyc < k + 34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy),    32'd0);
        check("midrst_ss_n", 32'(ss_n),    32'hF);
        check("midrst_sclk", 32'(sclk),    32'd0);
        check("midrst_mosi", 32'(mosi),    32'd0);
        check("midrst_rx",   32'(rx_data), 32'd0);
        check("midrst_done", 32'(done),    32'd0);
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // ignored starts mid-transfer, then back-to-back start in the DONE cycle
        d0 = done_cnt;
        go(2'd0, 0, 8'h11, 1'b1, 8'h11, 1'b1, k);
        while (cyc < k + 5) @(negedge clk);
        start = 1'b1; mode = 2'd3; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 40) @(negedge clk);
        start = 1'b1; mode = 2'd3; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        check("b2b_first_latency", 32'(done_cyc - k), 32'd73);
        start = 1'b1; mode = 2'd0; tx_data = 8'h5A;
        exp_q.push_back(8'h5A);
        k2 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", 32'(busy), 32'd1);
        wait_done(200);
        check("b2b_second_latency", 32'(done_cyc - k2), 32'd73);
        repeat (10) @(negedge clk);
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        // 16-bit word, CLK_DIV=1, mode 1, mosi looped to miso
        @(negedge clk);
        mode2 = 2'd1; tx2 = 16'hBEEF; start2 = 1'b1;
        exp_q2.push_back(16'hBEEF);
        k = cyc;
        target = done2_cnt + 1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done2_cnt >= target) break;
        end
        check("w16_done_seen", 32'(done2_cnt), 32'(target));
        check("w16_latency", 32'(done2_cyc - k), 32'd35);

        repeat (5) @(negedge clk);
        check("ss_n_profile",  32'(ss_bad),   32'd0);
        check("ss_n_rules",    32'(rule_bad), 32'd0);
        check("queue_drained", 32'(exp_q.size() + exp_q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised successor of the fixed 8-bit SPI master, clocked from the system clock. Adds configurable word width, clock divider and multiple slave selects. Supports all four SPI modes (CPOL/CPHA), selected per transfer. Has a start/busy/done handshake for a host controller and connects directly to existing spi_slave-style devices over sclk/mosi/miso/ss_n.

Parameters:
DATA_W, 8, bits per transfer (>=2)
NUM_SS, 1, number of slave-select lines (>=1)
SS_W, 1, width of ss_sel; must be >= max(1, clog2(NUM_SS))
CLK_DIV, 4, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request transfer; sampled when busy==0
mode  input  2  {CPOL,CPHA}; latched at start
ss_sel  input  SS_W  target slave index; latched at start
tx_data  input  DATA_W  word to send; latched at start
rx_data  output  DATA_W  last received word
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
sclk  output  1  SPI clock
mosi  output  1  master out
miso  input  1  master in
ss_n  output  NUM_SS  active-low slave selects

Behaviour:
- Reset (rst high at edge; overrides everything, including mid-transfer): state IDLE, busy=0, done=0, sclk=0, mosi=0, ss_n all 1, rx_data=0, latched mode=0.
- FSM: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
- IDLE: if start=1 and ss_sel<NUM_SS, latch tx_data/mode/ss_sel and go to LEAD. If ss_sel>=NUM_SS, ignore start: no busy, no done.
- LEAD (CLK_DIV cycles): busy=1, ss_n[ss_sel]=0, sclk=CPOL. If CPHA=0, mosi=tx MSB.
- XFER (2*DATA_W*CLK_DIV cycles): sclk toggles every CLK_DIV cycles, 2*DATA_W toggles total. sclk ends at CPOL.
  - CPHA=0: sample miso on leading edges; shift mosi on trailing edges except the last.
  - CPHA=1: drive next bit on leading edges; sample on trailing edges.
  - Bit order: MSB first.
- TRAIL (CLK_DIV cycles): sclk=CPOL, ss_n held asserted, mosi held.
- DONE (1 cycle): done=1, busy=0, ss_n all 1, mosi=0, rx_data updated with the assembled word. rx_data holds until the next DONE.
  - A start in this cycle is accepted as in IDLE (back-to-back). The next state is LEAD and ss_n reasserts the following cycle.
- Latency: start sampled at edge k gives busy=1 from k+1 and done at edge k+1+CLK_DIV*(2*DATA_W+2). Defaults give k+73.
- start while busy=1 (LEAD/XFER/TRAIL) is ignored; tx_data/mode/ss_sel changes are ignored until the next accept.
- rst and start in the same cycle: reset wins.
- Only one ss_n bit is ever low; all bits are high outside LEAD/XFER/TRAIL.
- Divider counter: range 0..CLK_DIV-1, wraps on each half-period. CLK_DIV=1 gives sclk at clk/2.

Optional Feature:
SPI_MASTER_LOOPBACK_EN defined: adds input port loopback (1 bit, after miso). When loopback=1 (latched at start), the receive path samples internal mosi instead of miso, and the sclk/ss_n/mosi pins still toggle normally.
Macro undefined: no loopback port; receive path always samples miso.

Test Plan:
- Loopback (or miso tied to mosi), mode 0, tx_data=0xA5, defaults -> rx_data=0xA5, done exactly 73 cycles after the start edge, 16 sclk toggles, busy high for 72 cycles.
- Slave model returns 0x3C, mode 3 (CPOL=1,CPHA=1), tx_data=0xC3 -> sclk idles 1, slave receives 0xC3, rx_data=0x3C.
- NUM_SS=4, ss_sel=2 -> ss_n=4'b1011 throughout LEAD..TRAIL, 4'b1111 otherwise. ss_sel=5 (SS_W=3) -> start ignored, no done.
- Reset mid-transfer: rst pulse at cycle 30 of XFER -> next edge busy=0, ss_n all 1, sclk=0, rx_data=0, no done pulse.
- start reasserted at cycles 5 and 40 of the transfer (ignored), then start in the DONE cycle with tx_data=0x5A -> second transfer begins immediately; rx_data=0x5A in loopback, two done pulses total.
- DATA_W=16, CLK_DIV=1, mode 1, loopback, tx_data=0xBEEF -> rx_data=0xBEEF, done at k+35.
